// File: rtl/hms_pkg.sv
// ---------------------------------------------------------------------------
// hms_pkg
// Shared definitions for the hours/minutes/seconds alarm timer.
//   field_e   : encoding of the field selected for editing in set mode
//   *_MAX     : highest legal value of each time field (inclusive)
// ---------------------------------------------------------------------------
package hms_pkg;

    // Which time field the set-mode edit pulses act on.
    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2,
        FIELD_NONE = 2'd3
    } field_e;

    // Inclusive upper bounds of the three time fields.
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage : hms_pkg

// File: rtl/hms_field.sv
// ---------------------------------------------------------------------------
// hms_field
// One modular time field (seconds, minutes or hours). Counts 0..max_i and
// wraps in either direction.
//   clk, rst  : system clock, asynchronous active-high reset (clears value)
//   max_i     : highest legal value of this field
//   carry_i   : advance by one as part of normal timekeeping (may ripple)
//   inc_i     : edit pulse, +1 modulo range, never produces a carry
//   dec_i     : edit pulse, -1 modulo range, never produces a borrow
//   value_o   : current field value
//   carry_o   : this field wraps max -> 0 because of carry_i this cycle
// ---------------------------------------------------------------------------
module hms_field #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] max_i,
    input  logic         carry_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         atMax;
    logic         atZero;

    assign atMax  = (value_q == max_i);
    assign atZero = (value_q == '0);

    // Next value: a timekeeping carry behaves like an increment. Edit pulses
    // that arrive together cancel out so the field is left alone. The top
    // level guarantees carries and edits are never active in the same cycle.
    always_comb begin
        value_d = value_q;
        if (carry_i || (inc_i && !dec_i)) begin
            value_d = atMax ? '0 : value_q + W'(1);
        end else if (dec_i && !inc_i) begin
            value_d = atZero ? max_i : value_q - W'(1);
        end
    end

    // Field register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    // Only a timekeeping carry ripples onward; edits stay inside the field.
    assign carry_o = carry_i && atMax;
    assign value_o = value_q;

endmodule : hms_field

// File: rtl/hms_alarm_timer.sv
// ---------------------------------------------------------------------------
// hms_alarm_timer
// 24-hour time-of-day clock with a one-second prescaler, a set mode for
// editing individual fields and N_ALARM sticky hour:minute alarms.
//   clk, rst      : system clock, asynchronous active-high reset
//   i_run         : enable timekeeping
//   i_set_en      : set mode (freezes timekeeping, enables edits)
//   i_set_field   : field to edit (hms_pkg::field_e encoding)
//   i_set_inc/dec : single-cycle edit pulses
//   i_alarm_wr    : write strobe for alarm channel i_alarm_sel
//   i_alarm_hour  : alarm hour to write (0..23)
//   i_alarm_min   : alarm minute to write (0..59)
//   i_alarm_en    : per-channel alarm enable (level)
//   i_alarm_clr   : clear all alarm flags
//   o_sec/min/hour: current time
//   o_tick        : one-cycle pulse each counted second
//   o_day_wrap    : one-cycle pulse on 23:59:59 -> 00:00:00
//   o_alarm       : sticky per-channel alarm flags
// ---------------------------------------------------------------------------
module hms_alarm_timer
    import hms_pkg::*;
#(
    parameter int DIV     = 50000000,
    parameter int N_ALARM = 2,
    parameter int AW      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    input  logic               i_set_en,
    input  logic [1:0]         i_set_field,
    input  logic               i_set_inc,
    input  logic               i_set_dec,
    input  logic               i_alarm_wr,
    input  logic [AW-1:0]      i_alarm_sel,
    input  logic [4:0]         i_alarm_hour,
    input  logic [5:0]         i_alarm_min,
    input  logic [N_ALARM-1:0] i_alarm_en,
    input  logic               i_alarm_clr,
    output logic [5:0]         o_sec,
    output logic [5:0]         o_min,
    output logic [4:0]         o_hour,
    output logic               o_tick,
    output logic               o_day_wrap,
    output logic [N_ALARM-1:0] o_alarm
);

    localparam int             PW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0]      preCnt_q;
    logic [PW-1:0]      preCnt_d;
    logic               setEnPrev_q;
    logic               tick_q;
    logic               dayWrap_q;

    logic               counting;
    logic               setRise;
    logic               tickEvent;

    logic               secInc;
    logic               secDec;
    logic               minInc;
    logic               minDec;
    logic               hourInc;
    logic               hourDec;

    logic [5:0]         secVal;
    logic [5:0]         minVal;
    logic [4:0]         hourVal;
    logic               secCarry;
    logic               minCarry;
    logic               hourCarry;

    logic               wrValid;
    logic               matchTime;
    logic [N_ALARM-1:0] alarmFlags;

    assign counting  = i_run && !i_set_en;
    assign setRise   = i_set_en && !setEnPrev_q;
    assign tickEvent = counting && (preCnt_q == PRE_LAST);

    // Prescaler next state. Entering set mode restarts the count so the
    // first second after leaving set mode is a full DIV cycles long; while
    // frozen (not running, or in set mode) the count simply holds.
    always_comb begin
        preCnt_d = preCnt_q;
        if (setRise) begin
            preCnt_d = '0;
        end else if (counting) begin
            preCnt_d = tickEvent ? '0 : preCnt_q + PW'(1);
        end
    end

    // Prescaler, set-mode edge detector and the registered tick/day-wrap
    // pulses. The pulses are registered on the same edge that advances the
    // time, so the new time and the pulse are visible together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preCnt_q    <= '0;
            setEnPrev_q <= 1'b0;
            tick_q      <= 1'b0;
            dayWrap_q   <= 1'b0;
        end else begin
            preCnt_q    <= preCnt_d;
            setEnPrev_q <= i_set_en;
            tick_q      <= tickEvent;
            dayWrap_q   <= hourCarry;
        end
    end

    // Route the edit pulses to the selected field, only while in set mode.
    always_comb begin
        secInc  = 1'b0;
        secDec  = 1'b0;
        minInc  = 1'b0;
        minDec  = 1'b0;
        hourInc = 1'b0;
        hourDec = 1'b0;
        if (i_set_en) begin
            case (i_set_field)
                FIELD_SEC: begin
                    secInc = i_set_inc;
                    secDec = i_set_dec;
                end
                FIELD_MIN: begin
                    minInc = i_set_inc;
                    minDec = i_set_dec;
                end
                FIELD_HOUR: begin
                    hourInc = i_set_inc;
                    hourDec = i_set_dec;
                end
                default: begin
                    secInc = 1'b0;
                end
            endcase
        end
    end

    hms_field #(.W(6)) uSec (
        .clk     (clk),
        .rst     (rst),
        .max_i   (SEC_MAX),
        .carry_i (tickEvent),
        .inc_i   (secInc),
        .dec_i   (secDec),
        .value_o (secVal),
        .carry_o (secCarry)
    );

    hms_field #(.W(6)) uMin (
        .clk     (clk),
        .rst     (rst),
        .max_i   (MIN_MAX),
        .carry_i (secCarry),
        .inc_i   (minInc),
        .dec_i   (minDec),
        .value_o (minVal),
        .carry_o (minCarry)
    );

    hms_field #(.W(5)) uHour (
        .clk     (clk),
        .rst     (rst),
        .max_i   (HOUR_MAX),
        .carry_i (minCarry),
        .inc_i   (hourInc),
        .dec_i   (hourDec),
        .value_o (hourVal),
        .carry_o (hourCarry)
    );

    // Out-of-range alarm values are dropped; out-of-range channel numbers
    // simply match no channel below.
    assign wrValid   = i_alarm_wr && (i_alarm_hour <= HOUR_MAX) &&
                       (i_alarm_min <= MIN_MAX);
    // Only a tick-produced time may fire an alarm, so set-mode edits that
    // land on an alarm time are harmless.
    assign matchTime = tick_q && (secVal == 6'd0);

    for (genvar k = 0; k < N_ALARM; k++) begin : gAlarm
        logic [4:0] hour_q;
        logic [5:0] min_q;
        logic       flag_q;
        logic       flag_d;
        logic       wrSel;
        logic       match;

        assign wrSel = wrValid && (i_alarm_sel == AW'(k));
        assign match = matchTime && i_alarm_en[k] &&
                       (hour_q == hourVal) && (min_q == minVal);

        // Sticky flag: a new match beats a simultaneous clear; disabling
        // the channel drops the flag.
        always_comb begin
            flag_d = flag_q;
            if (match) begin
                flag_d = 1'b1;
            end else if (i_alarm_clr || !i_alarm_en[k]) begin
                flag_d = 1'b0;
            end
        end

        // Alarm time storage and flag. The compare above uses the stored
        // value, so a write landing on a match cycle is judged on the old
        // alarm time.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hour_q <= '0;
                min_q  <= '0;
                flag_q <= 1'b0;
            end else begin
                if (wrSel) begin
                    hour_q <= i_alarm_hour;
                    min_q  <= i_alarm_min;
                end
                flag_q <= flag_d;
            end
        end

        assign alarmFlags[k] = flag_q;
    end

    assign o_sec      = secVal;
    assign o_min      = minVal;
    assign o_hour     = hourVal;
    assign o_tick     = tick_q;
    assign o_day_wrap = dayWrap_q;
    assign o_alarm    = alarmFlags;

endmodule : hms_alarm_timer

// File: tb/tb_hms_alarm_timer.sv
// ---------------------------------------------------------------------------
// tb_hms_alarm_timer
// Self-checking bench for hms_alarm_timer with DIV=4, N_ALARM=2.
// ---------------------------------------------------------------------------
module tb_hms_alarm_timer;
    import hms_pkg::*;

    localparam int DIV     = 4;
    localparam int N_ALARM = 2;
    localparam int AW      = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_run;
    logic               i_set_en;
    logic [1:0]         i_set_field;
    logic               i_set_inc;
    logic               i_set_dec;
    logic               i_alarm_wr;
    logic [AW-1:0]      i_alarm_sel;
    logic [4:0]         i_alarm_hour;
    logic [5:0]         i_alarm_min;
    logic [N_ALARM-1:0] i_alarm_en;
    logic               i_alarm_clr;
    logic [5:0]         o_sec;
    logic [5:0]         o_min;
    logic [4:0]         o_hour;
    logic               o_tick;
    logic               o_day_wrap;
    logic [N_ALARM-1:0] o_alarm;

    always #5 clk = ~clk;

    hms_alarm_timer #(.DIV(DIV), .N_ALARM(N_ALARM), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_run        (i_run),
        .i_set_en     (i_set_en),
        .i_set_field  (i_set_field),
        .i_set_inc    (i_set_inc),
        .i_set_dec    (i_set_dec),
        .i_alarm_wr   (i_alarm_wr),
        .i_alarm_sel  (i_alarm_sel),
        .i_alarm_hour (i_alarm_hour),
        .i_alarm_min  (i_alarm_min),
        .i_alarm_en   (i_alarm_en),
        .i_alarm_clr  (i_alarm_clr),
        .o_sec        (o_sec),
        .o_min        (o_min),
        .o_hour       (o_hour),
        .o_tick       (o_tick),
        .o_day_wrap   (o_day_wrap),
        .o_alarm      (o_alarm)
    );

    typedef struct {
        string      name;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic       tick;
        logic       wrap;
        logic [1:0] alarm;
    } exp_t;

    typedef struct {
        logic [1:0] field;
        logic       inc;
        logic       dec;
        int         sec;
        int         min;
        int         hour;
    } edit_t;

    exp_t  expQ[$];
    edit_t editTab[15];
    int    testsRun    = 0;
    int    testsFailed = 0;

    // Queue one expected output snapshot.
    task automatic pushExp(input string name, input int s, input int m,
                           input int h, input bit t, input bit w,
                           input logic [1:0] a);
        exp_t e;
        e.name  = name;
        e.sec   = 6'(s);
        e.min   = 6'(m);
        e.hour  = 5'(h);
        e.tick  = t;
        e.wrap  = w;
        e.alarm = a;
        expQ.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare against the DUT outputs now.
    task automatic checkOutput();
        exp_t e;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard: no expectation queued");
            return;
        end
        e = expQ.pop_front();
        if ({o_hour, o_min, o_sec, o_tick, o_day_wrap, o_alarm} !==
            {e.hour, e.min, e.sec, e.tick, e.wrap, e.alarm}) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d:%0d:%0d tick=%b wrap=%b alarm=%b, want %0d:%0d:%0d tick=%b wrap=%b alarm=%b",
                     e.name, o_hour, o_min, o_sec, o_tick, o_day_wrap, o_alarm,
                     e.hour, e.min, e.sec, e.tick, e.wrap, e.alarm);
        end
    endtask

    // One clocked cycle with an expected result after the edge.
    task automatic runCycle(input string name, input int s, input int m,
                            input int h, input bit t, input bit w,
                            input logic [1:0] a);
        pushExp(name, s, m, h, t, w, a);
        step();
        checkOutput();
    endtask

    // Apply one set-mode edit row and check the edited time.
    task automatic applyStimulus(input int idx, input edit_t r);
        i_set_field = r.field;
        i_set_inc   = r.inc;
        i_set_dec   = r.dec;
        runCycle($sformatf("edit[%0d]", idx), r.sec, r.min, r.hour, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        // Edit table: starts from 00:00:03, ends at 23:59:58.
        editTab[0]  = '{FIELD_SEC,  1'b0, 1'b1,  2,  0,  0};
        editTab[1]  = '{FIELD_SEC,  1'b0, 1'b1,  1,  0,  0};
        editTab[2]  = '{FIELD_SEC,  1'b0, 1'b1,  0,  0,  0};
        editTab[3]  = '{FIELD_SEC,  1'b0, 1'b1, 59,  0,  0};
        editTab[4]  = '{FIELD_SEC,  1'b1, 1'b0,  0,  0,  0};
        editTab[5]  = '{FIELD_MIN,  1'b1, 1'b0,  0,  1,  0};
        editTab[6]  = '{FIELD_SEC,  1'b1, 1'b1,  0,  1,  0};
        editTab[7]  = '{FIELD_NONE, 1'b1, 1'b0,  0,  1,  0};
        editTab[8]  = '{FIELD_HOUR, 1'b0, 1'b1,  0,  1, 23};
        editTab[9]  = '{FIELD_HOUR, 1'b1, 1'b0,  0,  1,  0};
        editTab[10] = '{FIELD_MIN,  1'b0, 1'b1,  0,  0,  0};
        editTab[11] = '{FIELD_MIN,  1'b0, 1'b1,  0, 59,  0};
        editTab[12] = '{FIELD_HOUR, 1'b0, 1'b1,  0, 59, 23};
        editTab[13] = '{FIELD_SEC,  1'b0, 1'b1, 59, 59, 23};
        editTab[14] = '{FIELD_SEC,  1'b0, 1'b1, 58, 59, 23};

        rst          = 1'b1;
        i_run        = 1'b0;
        i_set_en     = 1'b0;
        i_set_field  = FIELD_NONE;
        i_set_inc    = 1'b0;
        i_set_dec    = 1'b0;
        i_alarm_wr   = 1'b0;
        i_alarm_sel  = '0;
        i_alarm_hour = '0;
        i_alarm_min  = '0;
        i_alarm_en   = '0;
        i_alarm_clr  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        pushExp("reset", 0, 0, 0, 1'b0, 1'b0, 2'b00);
        checkOutput();

        // Free run: tick every DIV cycles after reset release.
        rst   = 1'b0;
        i_run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            runCycle($sformatf("run c%0d", c), c / 4, 0, 0, (c % 4) == 0, 1'b0, 2'b00);
        end

        // Set-mode edits from 00:00:03 down to 23:59:58.
        i_set_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(i, editTab[i]);
        end
        i_set_inc = 1'b0;
        i_set_dec = 1'b0;
        i_set_en  = 1'b0;

        // Two ticks through midnight; a stray edit pulse while running is ignored.
        i_set_field = FIELD_SEC;
        i_set_inc   = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c < 4) begin
                runCycle($sformatf("wrap c%0d", c), 58, 59, 23, 1'b0, 1'b0, 2'b00);
            end else if (c < 8) begin
                runCycle($sformatf("wrap c%0d", c), 59, 59, 23, c == 4, 1'b0, 2'b00);
            end else begin
                runCycle($sformatf("wrap c%0d", c), 0, 0, 0, c == 8, c == 8, 2'b00);
            end
            i_set_inc = 1'b0;
        end

        // Alarm 0 = 00:01, time set to 00:00:59 (entering set mode mid-count).
        i_set_en     = 1'b1;
        i_set_field  = FIELD_SEC;
        i_set_dec    = 1'b1;
        i_alarm_wr   = 1'b1;
        i_alarm_sel  = 1'b0;
        i_alarm_hour = 5'd0;
        i_alarm_min  = 6'd1;
        i_alarm_en   = 2'b01;
        runCycle("alarm preset", 59, 0, 0, 1'b0, 1'b0, 2'b00);
        i_set_dec  = 1'b0;
        i_alarm_wr = 1'b0;
        i_set_en   = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c < 4) begin
                runCycle($sformatf("alarm c%0d", c), 59, 0, 0, 1'b0, 1'b0, 2'b00);
            end else begin
                runCycle($sformatf("alarm c%0d", c), 0, 1, 0, c == 4, 1'b0,
                         (c >= 5) ? 2'b01 : 2'b00);
            end
        end
        // Clear, together with an out-of-range write that must be dropped.
        i_alarm_clr = 1'b1;
        i_alarm_wr  = 1'b1;
        i_alarm_min = 6'd60;
        runCycle("alarm clr", 0, 1, 0, 1'b0, 1'b0, 2'b00);
        i_alarm_clr = 1'b0;
        i_alarm_wr  = 1'b0;

        // Back to 00:00:59, then clear pulsed on the match cycle: set wins.
        i_set_en    = 1'b1;
        i_set_field = FIELD_MIN;
        i_set_dec   = 1'b1;
        runCycle("preset2 min", 0, 0, 0, 1'b0, 1'b0, 2'b00);
        i_set_field = FIELD_SEC;
        runCycle("preset2 sec", 59, 0, 0, 1'b0, 1'b0, 2'b00);
        i_set_dec = 1'b0;
        i_set_en  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c < 4) begin
                runCycle($sformatf("setwins c%0d", c), 59, 0, 0, 1'b0, 1'b0, 2'b00);
            end else begin
                runCycle("setwins tick", 0, 1, 0, 1'b1, 1'b0, 2'b00);
            end
        end
        i_alarm_clr = 1'b1;
        runCycle("setwins flag", 0, 1, 0, 1'b0, 1'b0, 2'b01);
        i_alarm_clr = 1'b0;
        i_alarm_en  = 2'b00;
        runCycle("disable clears", 0, 1, 0, 1'b0, 1'b0, 2'b00);
        i_alarm_en  = 2'b01;

        // Editing onto the alarm time never raises the alarm.
        i_set_en    = 1'b1;
        i_set_field = FIELD_SEC;
        i_set_dec   = 1'b1;
        runCycle("edit noalarm dec", 59, 1, 0, 1'b0, 1'b0, 2'b00);
        i_set_dec = 1'b0;
        i_set_inc = 1'b1;
        runCycle("edit noalarm inc", 0, 1, 0, 1'b0, 1'b0, 2'b00);
        i_set_inc = 1'b0;
        runCycle("edit noalarm hold", 0, 1, 0, 1'b0, 1'b0, 2'b00);

        // Preset 00:05:10, run two cycles (prescaler=2), then async reset.
        i_set_field = FIELD_MIN;
        i_set_inc   = 1'b1;
        repeat (4) step();
        i_set_field = FIELD_SEC;
        repeat (10) step();
        i_set_inc = 1'b0;
        runCycle("preset3", 10, 5, 0, 1'b0, 1'b0, 2'b00);
        i_set_en = 1'b0;
        runCycle("pre c1", 10, 5, 0, 1'b0, 1'b0, 2'b00);
        runCycle("pre c2", 10, 5, 0, 1'b0, 1'b0, 2'b00);
        rst = 1'b1;
        #1;
        pushExp("async reset", 0, 0, 0, 1'b0, 1'b0, 2'b00);
        checkOutput();
        repeat (2) step();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            runCycle($sformatf("post-reset c%0d", c), c / 4, 0, 0, c == 4, 1'b0, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_hms_alarm_timer
